// File: rtl/traffic_pkg.sv
// Shared pedestrian-phase types: state encoding plus ms-to-cycle and phase-end helpers.
package traffic_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WALK  = 2'd1,
    FLASH = 2'd2,
    DONE  = 2'd3
  } ped_state_t;

  localparam logic [63:0] MAX_CYCLES = 64'h0000_0000_FFFF_FFFF;

  // Evaluated at elaboration in 64 bits so the caller can range-check against 32 bits.
  function automatic logic [63:0] ms_to_cycles(input logic [63:0] ms, input logic [63:0] clk_freq);
    return ms * (clk_freq / 64'd1000);
  endfunction

  // True on the last cycle before count reaches limit; a zero limit still yields one cycle.
  function automatic logic phase_last(input logic [31:0] count, input logic [31:0] limit);
    return ({1'b0, count} + 33'd1) >= {1'b0, limit};
  endfunction

endpackage

// File: rtl/ped_btn_sync.sv
// Two-flop synchronizer for the asynchronous push-button plus a rising-edge detector.
module ped_btn_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic rise
);

  logic [2:0] sync_r;

  // Shift chain: [0],[1] synchronize, [2] holds the previous synchronized level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_r <= 3'b000;
    end else begin
      sync_r <= {sync_r[1:0], btn};
    end
  end

  assign rise = sync_r[1] & ~sync_r[2];

endmodule

// File: rtl/pedestrian_phase_sequencer.sv
// Pedestrian crossing phase sequencer: IDLE -> WALK -> FLASH -> DONE.
// Optional walk extension on a button press in WALK is enabled by macro PD_EXTEND_EN.
module pedestrian_phase_sequencer
  import traffic_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 32'd50_000_000,
  parameter int unsigned WALK_MS    = 32'd7000,
  parameter int unsigned CAUTION_MS = 32'd10000,
  parameter int unsigned EXTEND_MS  = 32'd3000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ped_btn,
  input  logic        ped_go,
  output logic        pd_req,
  output logic        pd_walk,
  output logic        pd_caution,
  output logic        pd_done,
  output logic [31:0] pd_counter,
  output logic [31:0] pd_free_cycles,
  output logic [31:0] pd_total_cycles
);

  localparam logic [63:0] FREE_W       = ms_to_cycles(64'(WALK_MS), 64'(CLK_FREQ));
  localparam logic [63:0] CAUTION_W    = ms_to_cycles(64'(CAUTION_MS), 64'(CLK_FREQ));
  localparam logic [63:0] EXTEND_W     = ms_to_cycles(64'(EXTEND_MS), 64'(CLK_FREQ));
  localparam logic [63:0] BASE_TOTAL_W = FREE_W + CAUTION_W;
`ifdef PD_EXTEND_EN
  localparam logic [63:0] PEAK_TOTAL_W = BASE_TOTAL_W + EXTEND_W;
  localparam logic [31:0] EXTEND_C     = EXTEND_W[31:0];
`else
  localparam logic [63:0] PEAK_TOTAL_W = BASE_TOTAL_W;
`endif
  localparam logic [31:0] FREE_C  = FREE_W[31:0];
  localparam logic [31:0] TOTAL_C = BASE_TOTAL_W[31:0];

  if ((FREE_W > MAX_CYCLES) || (EXTEND_W > MAX_CYCLES) || (PEAK_TOTAL_W > MAX_CYCLES)) begin : g_cycles_overflow
    $error("pedestrian_phase_sequencer: cycle constant does not fit in 32 bits");
  end

  ped_state_t  state_r, state_nxt;
  logic        pending_r, pending_nxt;
  logic [31:0] counter_r, counter_nxt, counter_inc;
  logic [31:0] free_r, free_nxt;
  logic [31:0] total_r, total_nxt;
  logic        btn_rise;
`ifdef PD_EXTEND_EN
  logic        extended_r, extended_nxt;
`endif

  ped_btn_sync u_btn_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (ped_btn),
    .rise  (btn_rise)
  );

  // Next-state, pending flag, counter and cycle-limit computation.
  always_comb begin
    state_nxt   = state_r;
    pending_nxt = pending_r;
    counter_nxt = counter_r;
    free_nxt    = free_r;
    total_nxt   = total_r;
`ifdef PD_EXTEND_EN
    extended_nxt = extended_r;
`endif
    counter_inc = (counter_r == 32'hFFFF_FFFF) ? counter_r : (counter_r + 32'd1);

    case (state_r)
      IDLE: begin
        if (pending_r && ped_go) begin
          state_nxt   = WALK;
          pending_nxt = btn_rise;
          counter_nxt = 32'd0;
          free_nxt    = FREE_C;
          total_nxt   = TOTAL_C;
`ifdef PD_EXTEND_EN
          extended_nxt = 1'b0;
`endif
        end else begin
          pending_nxt = pending_r | btn_rise;
        end
      end
      WALK: begin
        counter_nxt = counter_inc;
`ifdef PD_EXTEND_EN
        // The first press of the phase buys more walk time instead of queuing a crossing.
        if (btn_rise && !extended_r) begin
          extended_nxt = 1'b1;
          free_nxt     = free_r + EXTEND_C;
          total_nxt    = total_r + EXTEND_C;
        end else begin
          pending_nxt = pending_r | btn_rise;
        end
`else
        pending_nxt = pending_r | btn_rise;
`endif
        if (phase_last(counter_r, free_nxt)) begin
          state_nxt = FLASH;
        end else begin
          state_nxt = WALK;
        end
      end
      FLASH: begin
        counter_nxt = counter_inc;
        pending_nxt = pending_r | btn_rise;
        if (phase_last(counter_r, total_r)) begin
          state_nxt = DONE;
        end else begin
          state_nxt = FLASH;
        end
      end
      DONE: begin
        counter_nxt = 32'd0;
        pending_nxt = pending_r | btn_rise;
        state_nxt   = IDLE;
      end
      default: begin
        state_nxt   = IDLE;
        counter_nxt = 32'd0;
      end
    endcase
  end

  // State and output registers; outputs are decoded from next-state so they align with it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      pending_r  <= 1'b0;
      counter_r  <= 32'd0;
      free_r     <= 32'd0;
      total_r    <= 32'd0;
      pd_req     <= 1'b0;
      pd_walk    <= 1'b0;
      pd_caution <= 1'b0;
      pd_done    <= 1'b0;
`ifdef PD_EXTEND_EN
      extended_r <= 1'b0;
`endif
    end else begin
      state_r    <= state_nxt;
      pending_r  <= pending_nxt;
      counter_r  <= counter_nxt;
      free_r     <= free_nxt;
      total_r    <= total_nxt;
      pd_req     <= (state_nxt == IDLE) && pending_nxt;
      pd_walk    <= (state_nxt == WALK);
      pd_caution <= (state_nxt == FLASH);
      pd_done    <= (state_nxt == DONE);
`ifdef PD_EXTEND_EN
      extended_r <= extended_nxt;
`endif
    end
  end

  assign pd_counter      = counter_r;
  assign pd_free_cycles  = free_r;
  assign pd_total_cycles = total_r;

endmodule

// File: tb/tb_pedestrian_phase_sequencer.sv
// Scoreboard bench for pedestrian_phase_sequencer: directed scenarios plus randomized phases.
module tb_pedestrian_phase_sequencer;

  localparam int unsigned CLK_FREQ   = 10_000;
  localparam int unsigned WALK_MS    = 2;
  localparam int unsigned CAUTION_MS = 3;
  localparam int unsigned EXTEND_MS  = 1;
  localparam int unsigned CPMS       = CLK_FREQ / 1000;
  localparam int unsigned WALK_CY    = WALK_MS * CPMS;
  localparam int unsigned CAU_CY     = CAUTION_MS * CPMS;
  localparam int unsigned EXT_CY     = EXTEND_MS * CPMS;
`ifdef PD_EXTEND_EN
  localparam bit EXT_EN = 1'b1;
`else
  localparam bit EXT_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        ped_btn;
  logic        ped_go;
  logic        pd_req;
  logic        pd_walk;
  logic        pd_caution;
  logic        pd_done;
  logic [31:0] pd_counter;
  logic [31:0] pd_free_cycles;
  logic [31:0] pd_total_cycles;

  pedestrian_phase_sequencer #(
    .CLK_FREQ   (CLK_FREQ),
    .WALK_MS    (WALK_MS),
    .CAUTION_MS (CAUTION_MS),
    .EXTEND_MS  (EXTEND_MS)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ped_btn         (ped_btn),
    .ped_go          (ped_go),
    .pd_req          (pd_req),
    .pd_walk         (pd_walk),
    .pd_caution      (pd_caution),
    .pd_done         (pd_done),
    .pd_counter      (pd_counter),
    .pd_free_cycles  (pd_free_cycles),
    .pd_total_cycles (pd_total_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned walk_len;
    int unsigned caution_len;
    int unsigned free_c;
    int unsigned total_c;
    bit          req_after;
  } phase_t;

  phase_t exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected phase record built from the timing rules, not from the design.
  function automatic phase_t model_phase(input bit walk_press, input bit late_press);
    phase_t e;
    bit ext;
    ext           = walk_press && EXT_EN;
    e.walk_len    = WALK_CY + (ext ? EXT_CY : 0);
    e.caution_len = CAU_CY;
    e.free_c      = e.walk_len;
    e.total_c     = e.walk_len + CAU_CY;
    e.req_after   = late_press || (walk_press && !EXT_EN);
    return e;
  endfunction

  // Monitor: measure each phase and compare against the queued expectation on pd_done.
  int unsigned walk_seen;
  int unsigned caution_seen;
  bit          done_prev;
  phase_t      cur;
  always @(negedge clk) begin
    if (!rst_n) begin
      walk_seen    = 0;
      caution_seen = 0;
      done_prev    = 1'b0;
    end else begin
      if (pd_walk || pd_caution) check("walk_caution_exclusive", 64'(pd_walk & pd_caution), 64'd0);
      if (done_prev) begin
        check("done_width", 64'(pd_done), 64'd0);
        check("req_after_done", 64'(pd_req), 64'(cur.req_after));
        check("counter_after_done", 64'(pd_counter), 64'd0);
        done_prev = 1'b0;
      end
      if (pd_walk) walk_seen++;
      if (pd_caution) caution_seen++;
      if (pd_done) begin
        check("done_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          cur = exp_q.pop_front();
          check("walk_len", 64'(walk_seen), 64'(cur.walk_len));
          check("caution_len", 64'(caution_seen), 64'(cur.caution_len));
          check("free_cycles", 64'(pd_free_cycles), 64'(cur.free_c));
          check("total_cycles", 64'(pd_total_cycles), 64'(cur.total_c));
          done_prev = 1'b1;
        end
        walk_seen    = 0;
        caution_seen = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press();
    ped_btn = 1'b1;
    repeat (3) tick();
    ped_btn = 1'b0;
    repeat (3) tick();
  endtask

  task automatic go_pulse();
    ped_go = 1'b1;
    tick();
    ped_go = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_req"}, 64'(pd_req), 64'd0);
    check({name, "_walk"}, 64'(pd_walk), 64'd0);
    check({name, "_caution"}, 64'(pd_caution), 64'd0);
    check({name, "_done"}, 64'(pd_done), 64'd0);
    check({name, "_counter"}, 64'(pd_counter), 64'd0);
    check({name, "_free"}, 64'(pd_free_cycles), 64'd0);
    check({name, "_total"}, 64'(pd_total_cycles), 64'd0);
  endtask

  // sel: 0 = WALK, 1 = FLASH, 2 = either
  task automatic wait_count(input int unsigned k, input int sel);
    bit found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if ((pd_counter == k) &&
          ((sel == 0 && pd_walk) || (sel == 1 && pd_caution) || (sel == 2 && (pd_walk || pd_caution)))) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("wait_counter", 64'(found), 64'd1);
  endtask

  task automatic wait_done();
    bit found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (pd_done) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("wait_done", 64'(found), 64'd1);
    tick();
    tick();
  endtask

  task automatic wait_req();
    bit found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (pd_req) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("wait_req", 64'(found), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n   = 1'b0;
    ped_btn = 1'b0;
    ped_go  = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // ped_go without a request is ignored
    go_pulse();
    repeat (5) tick();
    check_all_zero("go_no_req");

    // Button rises at cycle 0 -> pd_req from cycle 3; ped_go at cycle 5 starts a full phase
    ped_btn = 1'b1;
    tick();
    check("req_cycle1", 64'(pd_req), 64'd0);
    tick();
    check("req_cycle2", 64'(pd_req), 64'd0);
    tick();
    check("req_cycle3", 64'(pd_req), 64'd1);
    ped_btn = 1'b0;
    tick();
    exp_q.push_back(model_phase(1'b0, 1'b0));
    go_pulse();
    check("go_walk", 64'(pd_walk), 64'd1);
    check("go_req_cleared", 64'(pd_req), 64'd0);
    check("go_counter", 64'(pd_counter), 64'd0);
    check("go_free", 64'(pd_free_cycles), 64'(WALK_CY));
    check("go_total", 64'(pd_total_cycles), 64'(WALK_CY + CAU_CY));
    repeat (3) begin
      go_pulse();
      check("go_ignored_walk", 64'(pd_walk), 64'd1);
    end
    wait_done();
    check("idle_after_phase", 64'(pd_walk | pd_caution | pd_done | pd_req), 64'd0);

    // Press during FLASH -> pd_req right after pd_done
    press();
    wait_req();
    exp_q.push_back(model_phase(1'b0, 1'b1));
    go_pulse();
    wait_count(25, 1);
    press();
    wait_done();

    // Edge detected on the FLASH-to-DONE edge is still captured
    exp_q.push_back(model_phase(1'b0, 1'b1));
    go_pulse();
    wait_count(WALK_CY + CAU_CY - 3, 1);
    ped_btn = 1'b1;
    repeat (3) tick();
    ped_btn = 1'b0;
    check("edge_at_done_pulse", 64'(pd_done), 64'd1);
    wait_done();
    check("edge_at_done_req", 64'(pd_req), 64'd1);

    // Reset mid-FLASH: everything clears and no pd_done follows
    go_pulse();
    wait_count(25, 1);
    rst_n = 1'b0;
    tick();
    check_all_zero("mid_reset");
    rst_n = 1'b1;
    repeat (60) tick();
    check_all_zero("post_reset");

`ifdef PD_EXTEND_EN
    // First WALK press extends once; a second WALK press only queues a crossing
    press();
    wait_req();
    exp_q.push_back(model_phase(1'b1, 1'b1));
    go_pulse();
    wait_count(5, 0);
    press();
    check("ext_free", 64'(pd_free_cycles), 64'(WALK_CY + EXT_CY));
    check("ext_total", 64'(pd_total_cycles), 64'(WALK_CY + EXT_CY + CAU_CY));
    wait_count(15, 0);
    press();
    check("ext_once_free", 64'(pd_free_cycles), 64'(WALK_CY + EXT_CY));
    check("ext_once_total", 64'(pd_total_cycles), 64'(WALK_CY + EXT_CY + CAU_CY));
    wait_done();
`endif

    // Randomized phases with presses at random points of WALK and later
    for (int iter = 0; iter < 10; iter++) begin
      int unsigned mode;
      int unsigned k;
      int unsigned f;
      bit walk_press;
      bit late_press;
      if (!pd_req) begin
        press();
        wait_req();
      end
      repeat ($urandom_range(0, 4)) tick();
      mode       = $urandom_range(0, 3);
      k          = $urandom_range(0, 14);
      f          = $urandom_range(22, 42);
      walk_press = (mode == 1) || (mode == 3);
      late_press = (mode >= 2);
      exp_q.push_back(model_phase(walk_press, late_press));
      go_pulse();
      if (walk_press) begin
        wait_count(k, 0);
        press();
      end
      if (late_press) begin
        wait_count(f, 2);
        press();
      end
      wait_done();
    end

    repeat (3) tick();
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
